// File: rtl/seq_lane_regfile_pkg.sv
// rtl/seq_lane_regfile_pkg.sv - shared types and sizing helpers for seq_lane_regfile
package seq_lane_regfile_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_COPY = 1'b1
  } commit_state_e;

  function automatic int lane_count(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // Keep index ports at least one bit wide even for degenerate sizes.
  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/seq_lane_reg.sv
// rtl/seq_lane_reg.sv - single lane-strobed register with async reset and sync clear
module seq_lane_reg
  import seq_lane_regfile_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              LANE_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sclr,
  input  logic                                  we,
  input  logic [lane_count(DATA_W, LANE_W)-1:0] strb,
  input  logic [DATA_W-1:0]                     d,
  output logic [DATA_W-1:0]                     q
);

  localparam int NL = lane_count(DATA_W, LANE_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (sclr) begin
      q <= RESET_VAL;
    end else if (we) begin
      for (int l = 0; l < NL; l++) begin
        if (strb[l]) q[l*LANE_W +: LANE_W] <= d[l*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/seq_lane_regfile.sv
// rtl/seq_lane_regfile.sv - strobed register file with optional shadow/commit copy
// Optional shadow copy and commit FSM enabled by SEQ_LANE_REGFILE_SHADOW_EN.
module seq_lane_regfile
  import seq_lane_regfile_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                LANE_W    = 4,
  parameter int                NUM_REGS  = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  sclr,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [idx_width(NUM_REGS)-1:0]        wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  input  logic [lane_count(DATA_W, LANE_W)-1:0] wr_strb,
  input  logic                                  rd_en,
  input  logic [idx_width(NUM_REGS)-1:0]        rd_addr,
  output logic [DATA_W-1:0]                     rd_data,
  output logic                                  rd_valid,
  input  logic                                  commit_req,
  output logic                                  commit_busy,
  output logic                                  commit_done,
  output logic [NUM_REGS-1:0]                   dirty
);

  localparam int NL    = lane_count(DATA_W, LANE_W);
  localparam int IDX_W = idx_width(NUM_REGS);

  logic [DATA_W-1:0] active_q [NUM_REGS];

  // Read samples the active copy before any same-edge write or clear lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= RESET_VAL;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= active_q[rd_addr];
    end
  end

`ifdef SEQ_LANE_REGFILE_SHADOW_EN

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  commit_state_e     state;
  logic [IDX_W-1:0]  copy_idx;
  logic              done_q;
  logic [NUM_REGS-1:0] dirty_q;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic              wr_fire;

  assign commit_busy = (state == ST_COPY);
  assign wr_ready    = ~commit_busy;
  assign commit_done = done_q;
  assign dirty       = dirty_q;
  assign wr_fire     = wr_valid & wr_ready;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    seq_lane_reg #(.DATA_W(DATA_W), .LANE_W(LANE_W), .RESET_VAL(RESET_VAL)) u_shadow (
      .clk  (clk),
      .rst  (rst),
      .sclr (sclr),
      .we   (wr_fire && (wr_addr == IDX_W'(i))),
      .strb (wr_strb),
      .d    (wr_data),
      .q    (shadow_q[i])
    );
    seq_lane_reg #(.DATA_W(DATA_W), .LANE_W(LANE_W), .RESET_VAL(RESET_VAL)) u_active (
      .clk  (clk),
      .rst  (rst),
      .sclr (sclr),
      .we   (commit_busy && (copy_idx == IDX_W'(i))),
      .strb ({NL{1'b1}}),
      .d    (shadow_q[i]),
      .q    (active_q[i])
    );
  end

  // Writes are blocked during COPY, so a dirty set and clear never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      copy_idx <= '0;
      done_q   <= 1'b0;
      dirty_q  <= '0;
    end else if (sclr) begin
      state    <= ST_IDLE;
      copy_idx <= '0;
      done_q   <= 1'b0;
      dirty_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (wr_fire) dirty_q[wr_addr] <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (commit_req) begin
            state    <= ST_COPY;
            copy_idx <= '0;
          end
        end
        default: begin
          dirty_q[copy_idx] <= 1'b0;
          if (copy_idx == LAST_IDX) begin
            state    <= ST_IDLE;
            copy_idx <= '0;
            done_q   <= 1'b1;
          end else begin
            copy_idx <= copy_idx + 1'b1;
          end
        end
      endcase
    end
  end

`else

  logic unused_commit_req;

  assign unused_commit_req = commit_req;
  assign wr_ready          = 1'b1;
  assign commit_busy       = 1'b0;
  assign commit_done       = 1'b0;
  assign dirty             = '0;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    seq_lane_reg #(.DATA_W(DATA_W), .LANE_W(LANE_W), .RESET_VAL(RESET_VAL)) u_active (
      .clk  (clk),
      .rst  (rst),
      .sclr (sclr),
      .we   (wr_valid && (wr_addr == IDX_W'(i))),
      .strb (wr_strb),
      .d    (wr_data),
      .q    (active_q[i])
    );
  end

`endif

endmodule
